// File: rtl/iocyc.sv
// iocyc: bus-cycle sequencer for the internal I/O register space.
// One accepted request walks SETUP -> [WAIT] -> DATA -> ACK -> TURN. Internal
// targets get a fixed wait count. External targets wait for ext_ack and are
// bounded by a saturating timeout. All outputs decode from registered state.
module iocyc #(
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 1,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic cyc_req,
  input  logic cyc_rd,
  input  logic cyc_int,
  input  logic ext_ack,
  output logic reads,
  output logic oet,
  output logic wet,
  output logic intswe,
  output logic intwe,
  output logic ourack,
  output logic buserr,
  output logic busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_WAIT, S_DATA, S_ACK, S_TURN
  } state_t;

  localparam logic [3:0]      RD_N   = 4'(RD_WAIT);
  localparam logic [3:0]      WR_N   = 4'(WR_WAIT);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LST = TO_W'(TIMEOUT - 1);

  state_t          state, nxt;
  logic            lat_rd, lat_int;
  logic [3:0]      wcnt;
  logic [TO_W-1:0] to_cnt;
  logic [3:0]      wait_n;

  assign wait_n = lat_rd ? RD_N : WR_N;

  // State register; reset drops any in-flight cycle without an ack.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  // Next-state logic; a dropped cyc_req before ACK aborts back to IDLE.
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (cyc_req) nxt = S_SETUP;
      S_SETUP: begin
        if (!cyc_req)                     nxt = S_IDLE;
        else if (lat_int && wait_n == '0) nxt = S_DATA;
        else                              nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!cyc_req)                     nxt = S_IDLE;
        else if (lat_int) begin
          if (wcnt <= 4'd1)               nxt = S_DATA;
        end else if (ext_ack)             nxt = S_DATA;   // ack beats timeout
        else if (to_cnt >= TO_LST)        nxt = S_ACK;    // timeout skips DATA
      end
      S_DATA:  nxt = cyc_req ? S_ACK : S_IDLE;
      S_ACK:   nxt = S_TURN;
      S_TURN:  nxt = S_IDLE;                              // request ignored here
      default: nxt = S_IDLE;
    endcase
  end

  // Request attributes latched at acceptance, held for the whole cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_rd  <= 1'b1;
      lat_int <= 1'b0;
    end else if (state == S_IDLE && cyc_req) begin
      lat_rd  <= cyc_rd;
      lat_int <= cyc_int;
    end
  end

  // Internal wait down-counter: loaded at acceptance, cleared on abort.
  always_ff @(posedge clk) begin
    if (reset)                              wcnt <= '0;
    else if (state == S_IDLE && cyc_req)    wcnt <= cyc_rd ? RD_N : WR_N;
    else if (nxt == S_IDLE)                 wcnt <= '0;
    else if (state == S_WAIT && lat_int && wcnt != '0)
                                            wcnt <= wcnt - 4'd1;
  end

  // External timeout counter: saturates at TIMEOUT, which marks a bus error.
  always_ff @(posedge clk) begin
    if (reset)                                     to_cnt <= '0;
    else if (nxt == S_SETUP || nxt == S_IDLE)      to_cnt <= '0;
    else if (state == S_WAIT && !lat_int && !ext_ack && to_cnt != TO_MAX)
                                                   to_cnt <= to_cnt + 1'b1;
  end

  // Moore output decode from state and latched attributes.
  always_comb begin
    reads  = 1'b1;
    oet    = 1'b0;
    wet    = 1'b0;
    intswe = 1'b0;
    intwe  = 1'b0;
    ourack = 1'b0;
    buserr = 1'b0;
    busy   = (state != S_IDLE);
    if (state != S_IDLE && state != S_TURN) reads = lat_rd;
    if (state == S_WAIT || state == S_DATA) begin
      oet   = lat_int &  lat_rd;
      wet   = lat_int & ~lat_rd;
      intwe = ~lat_rd;
    end
    if (state == S_DATA) intswe = lat_int & ~lat_rd;
    if (state == S_ACK) begin
      ourack = 1'b1;
      buserr = (to_cnt == TO_MAX);
    end
  end

endmodule

// File: tb/tb_iocyc.sv
// tb_iocyc: directed vector table over two iocyc instances sharing stimulus.
// Instance a: RD_WAIT=1 WR_WAIT=0 TIMEOUT=4. Instance b: RD_WAIT=1 WR_WAIT=2
// TIMEOUT=255. Output byte = {reads,oet,wet,intswe,intwe,ourack,buserr,busy}.
module tb_iocyc;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cyc_req = 1'b0, cyc_rd = 1'b0, cyc_int = 1'b0, ext_ack = 1'b0;

  logic reads_a, oet_a, wet_a, intswe_a, intwe_a, ourack_a, buserr_a, busy_a;
  logic reads_b, oet_b, wet_b, intswe_b, intwe_b, ourack_b, buserr_b, busy_b;
  logic [7:0] oa, ob;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  iocyc #(.RD_WAIT(1), .WR_WAIT(0), .TIMEOUT(4), .TO_W(8)) u_a (
    .clk(clk), .reset(reset), .cyc_req(cyc_req), .cyc_rd(cyc_rd),
    .cyc_int(cyc_int), .ext_ack(ext_ack), .reads(reads_a), .oet(oet_a),
    .wet(wet_a), .intswe(intswe_a), .intwe(intwe_a), .ourack(ourack_a),
    .buserr(buserr_a), .busy(busy_a));

  iocyc #(.RD_WAIT(1), .WR_WAIT(2), .TIMEOUT(255), .TO_W(8)) u_b (
    .clk(clk), .reset(reset), .cyc_req(cyc_req), .cyc_rd(cyc_rd),
    .cyc_int(cyc_int), .ext_ack(ext_ack), .reads(reads_b), .oet(oet_b),
    .wet(wet_b), .intswe(intswe_b), .intwe(intwe_b), .ourack(ourack_b),
    .buserr(buserr_b), .busy(busy_b));

  assign oa = {reads_a, oet_a, wet_a, intswe_a, intwe_a, ourack_a, buserr_a, busy_a};
  assign ob = {reads_b, oet_b, wet_b, intswe_b, intwe_b, ourack_b, buserr_b, busy_b};

  typedef struct {
    bit         sel;   // 0 = check u_a, 1 = check u_b
    bit         rst;
    bit         req;
    bit         rd;
    bit         it;
    bit         ack;
    logic [7:0] exp;
    string      nm;
  } vec_t;

  vec_t tv[$];

  task automatic add(input bit s, r, q, d, i, a, input logic [7:0] e, input string n);
    vec_t v;
    v.sel = s; v.rst = r; v.req = q; v.rd = d; v.it = i; v.ack = a; v.exp = e; v.nm = n;
    tv.push_back(v);
  endtask

  // Drive inputs mid-cycle, let one edge happen, then sample just after it.
  task automatic step(input bit r, q, d, i, a);
    @(negedge clk);
    reset = r; cyc_req = q; cyc_rd = d; cyc_int = i; ext_ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [7:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", n, act, exp);
    end
  endtask

  initial begin
    int k;
    // ---------------- instance a ----------------
    add(0,1,0,0,0,0, 8'h80, "a_reset");
    add(0,0,0,1,1,0, 8'h80, "a_idle_noreq");
    // internal read, one wait state; rd/int changed after accept to prove latching
    add(0,0,1,1,1,0, 8'h81, "rd_setup");
    add(0,0,1,0,0,0, 8'hC1, "rd_wait");
    add(0,0,1,0,0,0, 8'hC1, "rd_data");
    add(0,0,1,0,0,0, 8'h85, "rd_ack");
    add(0,0,0,0,0,0, 8'h81, "rd_turn");
    add(0,0,0,0,0,0, 8'h80, "rd_idle");
    // internal write, zero wait: no WAIT state
    add(0,0,1,0,1,0, 8'h01, "wr_setup");
    add(0,0,1,0,1,0, 8'h39, "wr_data");
    add(0,0,1,0,1,0, 8'h05, "wr_ack");
    add(0,0,0,0,0,0, 8'h81, "wr_turn");
    add(0,0,0,0,0,0, 8'h80, "wr_idle");
    // external read, no ext_ack: 4 WAIT cycles then ACK with buserr, no DATA
    add(0,0,1,1,0,0, 8'h81, "to_setup");
    for (int j = 0; j < 4; j++) add(0,0,1,1,0,0, 8'h81, "to_wait");
    add(0,0,1,1,0,0, 8'h87, "to_ack_err");
    add(0,0,0,0,0,0, 8'h81, "to_turn");
    add(0,0,0,0,0,0, 8'h80, "to_idle");
    // no reset: timeout count must clear on SETUP; ack on the timeout cycle wins
    add(0,0,1,1,0,0, 8'h81, "aw_setup");
    for (int j = 0; j < 4; j++) add(0,0,1,1,0,0, 8'h81, "aw_wait");
    add(0,0,1,1,0,1, 8'h81, "aw_data");
    add(0,0,1,1,0,0, 8'h85, "aw_ack_noerr");
    add(0,0,0,0,0,0, 8'h81, "aw_turn");
    add(0,0,0,0,0,0, 8'h80, "aw_idle");
    // req held high through ACK: TURN ignores it, IDLE then re-accepts
    add(0,0,1,1,1,0, 8'h81, "b2b_setup");
    add(0,0,1,1,1,0, 8'hC1, "b2b_wait");
    add(0,0,1,1,1,0, 8'hC1, "b2b_data");
    add(0,0,1,1,1,0, 8'h85, "b2b_ack");
    add(0,0,1,1,1,0, 8'h81, "b2b_turn");
    add(0,0,1,1,1,0, 8'h80, "b2b_idle");
    add(0,0,1,1,1,0, 8'h81, "b2b_setup2");
    add(0,0,0,1,1,0, 8'h80, "abort_setup");
    // ---------------- instance b ----------------
    add(1,1,0,0,0,0, 8'h80, "b_reset");
    // external write, ext_ack sampled at the end of the 5th WAIT cycle
    add(1,0,1,0,0,0, 8'h01, "xw_setup");
    for (int j = 0; j < 5; j++) add(1,0,1,0,0,0, 8'h09, "xw_wait");
    add(1,0,1,0,0,1, 8'h09, "xw_data");
    add(1,0,1,0,0,0, 8'h05, "xw_ack");
    add(1,0,0,0,0,0, 8'h81, "xw_turn");
    add(1,0,0,0,0,0, 8'h80, "xw_idle");
    // internal write, two wait states
    add(1,0,1,0,1,0, 8'h01, "iw_setup");
    add(1,0,1,0,1,0, 8'h29, "iw_wait1");
    add(1,0,1,0,1,0, 8'h29, "iw_wait2");
    add(1,0,1,0,1,0, 8'h39, "iw_data");
    add(1,0,1,0,1,0, 8'h05, "iw_ack");
    add(1,0,0,0,0,0, 8'h81, "iw_turn");
    add(1,0,0,0,0,0, 8'h80, "iw_idle");
    // abort in WAIT of an internal write: no intswe, no ack
    add(1,0,1,0,1,0, 8'h01, "ab_setup");
    add(1,0,1,0,1,0, 8'h29, "ab_wait");
    add(1,0,0,0,1,0, 8'h80, "ab_idle");
    add(1,0,0,0,1,0, 8'h80, "ab_hold");
    // reset mid-WAIT of an internal read
    add(1,0,1,1,1,0, 8'h81, "rw_setup");
    add(1,0,1,1,1,0, 8'hC1, "rw_wait");
    add(1,1,1,1,1,0, 8'h80, "rw_reset");
    add(1,0,0,0,0,0, 8'h80, "rw_post");

    foreach (tv[j]) begin
      step(tv[j].rst, tv[j].req, tv[j].rd, tv[j].it, tv[j].ack);
      chk(tv[j].nm, tv[j].sel ? ob : oa, tv[j].exp);
    end

    // Hand sequence: internal read latency on b, ourack in cycle N+2 = 3.
    step(1,0,0,0,0);
    step(0,1,1,1,0);          // accept -> SETUP (cycle 0)
    k = 0;
    while (!ourack_b && k < 20) begin
      step(0,1,1,1,0);
      k++;
    end
    n_cmp++;
    if (k != 3) begin
      n_err++;
      $display("FAIL lat_b: ourack after %0d cycles expected 3", k);
    end
    chk("lat_b_noerr", {7'd0, buserr_b}, 8'd0);
    // ourack lasts exactly one cycle
    step(0,1,1,1,0);
    chk("lat_b_ack_once", {7'd0, ourack_b}, 8'd0);
    step(0,0,0,0,0);
    step(0,0,0,0,0);
    chk("lat_b_idle", ob, 8'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
